// File: rtl/rc5_pkg.sv
// ---------------------------------------------------------------------------
// rc5_pkg : shared RC5 widths, FSM encoding and key-schedule magic constants
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rc5_pkg;

  localparam int RC5_W        = 32;
  localparam int RC5_R        = 12;
  localparam int RC5_T        = 2 * (RC5_R + 1);
  localparam int RC5_W_BITS   = $clog2(RC5_W);
  localparam int RC5_T_LENGTH = $clog2(RC5_T);

  // Key-expander seeds for W=32 (odd((e-2)*2^32), odd((phi-1)*2^32))
  localparam logic [31:0] RC5_P32 = 32'hB7E1_5163;
  localparam logic [31:0] RC5_Q32 = 32'h9E37_79B9;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_RUN      = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rc5_rotl.sv
// ---------------------------------------------------------------------------
// rc5_rotl : combinational W-bit rotate-left by a W_BITS-wide amount
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rc5_rotl #(
  parameter int W = 32,
  localparam int W_BITS = $clog2(W)
) (
  input  logic [W-1:0]      word,
  input  logic [W_BITS-1:0] amount,
  output logic [W-1:0]      rotated
);

  // Bits shifted out of the low copy land in the upper half.
  logic [2*W-1:0] doubled;

  assign doubled = {word, word} << amount;
  assign rotated = doubled[2*W-1:W];

endmodule

`default_nettype wire

// File: rtl/rc5_encrypt_core.sv
// ---------------------------------------------------------------------------
// rc5_encrypt_core : RC5-W/R encryption, one half-round per S-table word read
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rc5_encrypt_core
  import rc5_pkg::*;
#(
  parameter int W = RC5_W,
  parameter int R = RC5_R,
  localparam int T        = 2 * (R + 1),
  localparam int W_BITS   = $clog2(W),
  localparam int T_LENGTH = $clog2(T)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iKeyReady,
  input  logic                iStart,
  input  logic [W-1:0]        iPlainA,
  input  logic [W-1:0]        iPlainB,
  output logic [T_LENGTH-1:0] oS_address,
  input  logic [W-1:0]        iS_sub_i,
  output logic [W-1:0]        oCipherA,
  output logic [W-1:0]        oCipherB,
  output logic                oBusy,
  output logic                oDone
);

  localparam logic [T_LENGTH-1:0] J_LAST = T_LENGTH'(T - 1);

  state_t              state;
  logic [T_LENGTH-1:0] j;
  logic [W-1:0]        a;
  logic [W-1:0]        b;
  logic [W_BITS-1:0]   rot_amount;
  logic [W-1:0]        rot_out;
  logic [W-1:0]        mix;
  logic                first_pair;
  logic [T_LENGTH-1:0] addr_next;

  // A^B == B^A, so one rotator serves both halves; only the amount differs.
  assign rot_amount = j[0] ? a[W_BITS-1:0] : b[W_BITS-1:0];

  rc5_rotl #(.W(W)) u_rotl (
    .word    (a ^ b),
    .amount  (rot_amount),
    .rotated (rot_out)
  );

  assign first_pair = (j[T_LENGTH-1:1] == '0);
  assign mix        = first_pair ? ((j[0] ? b : a) + iS_sub_i) : (rot_out + iS_sub_i);

  // Address runs one word ahead of j to cover the RAM read latency.
  assign addr_next = (j >= J_LAST - T_LENGTH'(1)) ? J_LAST : j + T_LENGTH'(2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      j          <= '0;
      a          <= '0;
      b          <= '0;
      oS_address <= '0;
      oCipherA   <= '0;
      oCipherB   <= '0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iStart && iKeyReady) begin
            a          <= iPlainA;
            b          <= iPlainB;
            oS_address <= '0;
            oBusy      <= 1'b1;
            state      <= ST_PREFETCH;
          end
        end
        ST_PREFETCH: begin
          j          <= '0;
          oS_address <= T_LENGTH'(1);
          state      <= ST_RUN;
        end
        ST_RUN: begin
          if (j[0]) b <= mix;
          else      a <= mix;
          if (j == J_LAST) begin
            j          <= '0;
            oS_address <= '0;
            oBusy      <= 1'b0;
            state      <= ST_DONE;
          end else begin
            j          <= j + T_LENGTH'(1);
            oS_address <= addr_next;
          end
        end
        ST_DONE: begin
          oCipherA <= a;
          oCipherB <= b;
          oDone    <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rc5_encrypt_core.sv
// ---------------------------------------------------------------------------
// tb_rc5_encrypt_core : vector table plus directed corner sequences
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rc5_encrypt_core;

  localparam int T = 26;
  localparam int LAT = T + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iKeyReady = 1'b0;
  logic        iStart = 1'b0;
  logic [31:0] iPlainA = '0;
  logic [31:0] iPlainB = '0;
  logic [4:0]  oS_address;
  logic [31:0] iS_sub_i;
  logic [31:0] oCipherA;
  logic [31:0] oCipherB;
  logic        oBusy;
  logic        oDone;

  logic [31:0] s_mem [0:T-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rc5_encrypt_core dut (
    .clk        (clk),
    .rst        (rst),
    .iKeyReady  (iKeyReady),
    .iStart     (iStart),
    .iPlainA    (iPlainA),
    .iPlainB    (iPlainB),
    .oS_address (oS_address),
    .iS_sub_i   (iS_sub_i),
    .oCipherA   (oCipherA),
    .oCipherB   (oCipherB),
    .oBusy      (oBusy),
    .oDone      (oDone)
  );

  // S RAM with one cycle of read latency
  always @(posedge clk) iS_sub_i <= s_mem[oS_address];

  function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
    int k;
    k = n & 31;
    return (k == 0) ? v : ((v << k) | (v >> (32 - k)));
  endfunction

  task automatic load_zero_s();
    for (int i = 0; i < T; i++) s_mem[i] = '0;
  endtask

  task automatic load_key(input logic [31:0] l0, l1, l2, l3);
    logic [31:0] l [4];
    logic [31:0] x, y;
    int si, li;
    l[0] = l0; l[1] = l1; l[2] = l2; l[3] = l3;
    s_mem[0] = 32'hB7E15163;
    for (int i = 1; i < T; i++) s_mem[i] = s_mem[i-1] + 32'h9E3779B9;
    x = '0; y = '0; si = 0; li = 0;
    for (int n = 0; n < 3 * T; n++) begin
      x = rotl32(s_mem[si] + x + y, 3);
      s_mem[si] = x;
      y = rotl32(l[li] + x + y, int'(x + y));
      l[li] = y;
      si = (si + 1) % T;
      li = (li + 1) % 4;
    end
  endtask

  function automatic logic [63:0] enc_model(input logic [31:0] pa, pb);
    logic [31:0] ma, mb;
    ma = pa + s_mem[0];
    mb = pb + s_mem[1];
    for (int i = 1; i <= 12; i++) begin
      ma = rotl32(ma ^ mb, int'(mb[4:0])) + s_mem[2*i];
      mb = rotl32(mb ^ ma, int'(ma[4:0])) + s_mem[2*i+1];
    end
    return {ma, mb};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns cycles from accept edge to oDone.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (oDone) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic do_block(input logic [31:0] pa, pb, output int lat);
    iPlainA = pa; iPlainB = pb; iStart = 1'b1; iKeyReady = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0; iPlainA = ~pa; iPlainB = ~pb;
    wait_done(lat);
  endtask

  typedef struct {
    int          key_sel;   // 0: all-zero S, 1: zero 16-byte key, 2: Rivest vector-2 key
    bit          use_model;
    logic [31:0] pa, pb, ea, eb;
  } vec_t;

  vec_t vecs [6];

  task automatic select_key(input int sel);
    case (sel)
      0:       load_zero_s();
      1:       load_key(32'h0, 32'h0, 32'h0, 32'h0);
      default: load_key(32'h19465F91, 32'h51B241BE, 32'h01A55563, 32'h91CEA910);
    endcase
  endtask

  initial begin
    int lat;
    int dones;
    logic [31:0] ca, cb;
    logic [63:0] m;

    vecs[0] = '{0, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[1] = '{1, 1'b0, 32'h00000000, 32'h00000000, 32'hEEDBA521, 32'h6D8F4B15};
    vecs[2] = '{2, 1'b0, 32'hEEDBA521, 32'h6D8F4B15, 32'hAC13C0F7, 32'h52892B5B};
    vecs[3] = '{2, 1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0};
    vecs[4] = '{0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0};
    vecs[5] = '{1, 1'b1, 32'h80000000, 32'h00000001, 32'h0, 32'h0};

    load_zero_s();
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr",  32'(oS_address), 32'h0);
    check("rst_ca",    oCipherA, 32'h0);
    check("rst_cb",    oCipherB, 32'h0);
    check("rst_busy",  32'(oBusy), 32'h0);
    check("rst_done",  32'(oDone), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      select_key(vecs[i].key_sel);
      if (vecs[i].use_model) begin
        m = enc_model(vecs[i].pa, vecs[i].pb);
        vecs[i].ea = m[63:32];
        vecs[i].eb = m[31:0];
      end
      do_block(vecs[i].pa, vecs[i].pb, lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(LAT));
      check($sformatf("vec%0d_ca", i), oCipherA, vecs[i].ea);
      check($sformatf("vec%0d_cb", i), oCipherB, vecs[i].eb);
      @(posedge clk); #1;
    end

    // Address trace and busy window
    select_key(1);
    iPlainA = '0; iPlainB = '0; iStart = 1'b1; iKeyReady = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    for (int k = 0; k <= 26; k++) begin
      check($sformatf("trace_addr%0d", k), 32'(oS_address), (k < 25) ? 32'(k) : 32'd25);
      check($sformatf("trace_busy%0d", k), 32'(oBusy), 32'h1);
      @(posedge clk); #1;
    end
    check("trace_done_busy", 32'(oBusy), 32'h0);
    check("trace_done_early", 32'(oDone), 32'h0);
    @(posedge clk); #1;
    check("trace_done", 32'(oDone), 32'h1);
    check("trace_ca", oCipherA, 32'hEEDBA521);
    check("trace_cb", oCipherB, 32'h6D8F4B15);
    @(posedge clk); #1;

    // Start requests without key ready are dropped
    select_key(2);
    iKeyReady = 1'b0; iStart = 1'b1; iPlainA = 32'hDEADBEEF; iPlainB = 32'hCAFEF00D;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("nokey_busy%0d", k), 32'(oBusy), 32'h0);
    end
    iKeyReady = 1'b1; iPlainA = 32'hEEDBA521; iPlainB = 32'h6D8F4B15;
    @(posedge clk); #1;
    check("nokey_accept", 32'(oBusy), 32'h1);
    iStart = 1'b0;
    wait_done(lat);
    check("nokey_lat", 32'(lat), 32'(LAT));
    check("nokey_ca", oCipherA, 32'hAC13C0F7);
    check("nokey_cb", oCipherB, 32'h52892B5B);
    @(posedge clk); #1;

    // Second request mid-run and key-ready drop are both ignored
    select_key(1);
    iPlainA = '0; iPlainB = '0; iStart = 1'b1; iKeyReady = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    dones = 0; lat = -1; ca = '0; cb = '0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (oDone) begin
        dones++;
        if (lat < 0) begin
          lat = n; ca = oCipherA; cb = oCipherB;
        end
      end
      if (n == 5)  iKeyReady = 1'b0;
      if (n == 9)  begin iStart = 1'b1; iPlainA = 32'h11111111; iPlainB = 32'h22222222; end
      if (n == 10) iStart = 1'b0;
    end
    check("midreq_lat", 32'(lat), 32'(LAT));
    check("midreq_dones", 32'(dones), 32'h1);
    check("midreq_ca", ca, 32'hEEDBA521);
    check("midreq_cb", cb, 32'h6D8F4B15);

    // Reset during RUN at j=12
    select_key(2);
    iPlainA = 32'hEEDBA521; iPlainB = 32'h6D8F4B15; iStart = 1'b1; iKeyReady = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    repeat (13) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 32'(oBusy), 32'h0);
    check("midrst_addr", 32'(oS_address), 32'h0);
    check("midrst_ca", oCipherA, 32'h0);
    check("midrst_cb", oCipherB, 32'h0);
    check("midrst_done", 32'(oDone), 32'h0);
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (oDone) dones++;
    end
    check("midrst_nodone", 32'(dones), 32'h0);
    do_block(32'hEEDBA521, 32'h6D8F4B15, lat);
    check("postrst_lat", 32'(lat), 32'(LAT));
    check("postrst_ca", oCipherA, 32'hAC13C0F7);
    check("postrst_cb", oCipherB, 32'h52892B5B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rc5_encrypt_core.md
Name: rc5_encrypt_core

Overview:
Block-cipher datapath that consumes the expanded key table S written by the key expander. It encrypts one 2-word block per request with RC5-W/R/B. It reads S[0..T-1] in order through the S-memory read port, one word per cycle, and applies one half-round per word. It sits beside the key expander on the shared S RAM. It may start only after key expansion has completed.

Parameters:
W, 32, word size in bits
R, 12, number of rounds
T, 2*(R+1), S-table length (derived; not to be overridden)
W_BITS, $clog2(W), rotate-amount width
T_LENGTH, $clog2(T), S address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
iKeyReady  in  1  high once key expansion is done (driven from the expander's done flag)
iStart  in  1  request to encrypt; sampled only in IDLE
iPlainA  in  W  plaintext word A, sampled with an accepted iStart
iPlainB  in  W  plaintext word B, sampled with an accepted iStart
oS_address  out  T_LENGTH  S RAM read address
iS_sub_i  in  W  S RAM read data, valid for the address presented in the previous cycle
oCipherA  out  W  ciphertext word A
oCipherB  out  W  ciphertext word B
oBusy  out  1  high from the cycle after acceptance through the final half-round
oDone  out  1  one-cycle pulse when oCipherA/oCipherB become valid

Behaviour:
- One clock, clk; reset rst is synchronous, active-high.
- Reset values:
  - oS_address=0, oCipherA=0, oCipherB=0, oBusy=0, oDone=0.
  - State=IDLE, half-round counter j=0.
- States: IDLE, PREFETCH, RUN, DONE.
- IDLE:
  - Accept when iStart && iKeyReady: latch A<=iPlainA, B<=iPlainB; go to PREFETCH.
  - iStart without iKeyReady is ignored; nothing is latched and it does not stay pending.
- PREFETCH (1 cycle):
  - oS_address=0, oBusy=1; go to RUN with j=0.
- RUN (T cycles):
  - Each cycle, oS_address=j+1, saturating at T-1 on the last cycle.
  - iS_sub_i carries S[j].
  - End-of-cycle update:
    - j=0: A<=A+S[0]
    - j=1: B<=B+S[1]
    - j even >=2: A<=rotl(A^B, B[W_BITS-1:0])+S[j]
    - j odd >=3: B<=rotl(B^A, A[W_BITS-1:0])+S[j], using the already-updated A register
  - j increments each cycle. After j=T-1, go to DONE.
- DONE (1 cycle):
  - oCipherA/oCipherB<=A/B, oDone=1, oBusy=0; return to IDLE.
- Latency: oDone asserts exactly T+2 cycles after the accepting edge (28 for R=12). The next iStart can be accepted in the cycle after oDone.
- Arithmetic: all additions are mod 2^W; carries are discarded. A rotate amount of 0 is identity. Only the low W_BITS of the rotating word are used.
- oCipherA/oCipherB hold their value until the next DONE or reset.
- iStart while oBusy: ignored; no queueing.
- iPlainA/iPlainB changes after acceptance: no effect.
- iKeyReady falling during PREFETCH/RUN: ignored; the operation completes. S must not be rewritten while oBusy (system rule, not checked).
- rst mid-operation: return to IDLE next edge, all outputs to reset values, no oDone.
- The block never writes S and has no write enable.

Decomposition:
- Shared package rc5_pkg: W, R, T, W_BITS, T_LENGTH defaults; state encoding; P/Q magic constants for shared use with the key expander.
- One sub-module: rc5_rotl (combinational, parameter W; word and amount in, rotated word out). It is reused by the key mixer and a future decrypt core.
- FSM and datapath registers use FFD_POSEDGE_SYNCRONOUS_RESET instances where registered.

Test Plan:
- All-zero S table, plaintext A=0x00000000, B=0x00000000 -> ciphertext 0x00000000/0x00000000; oDone exactly 28 cycles after acceptance.
- S from the key expander with a 16 zero-byte key, plaintext words 0/0 -> oCipherA=0xEEDBA521, oCipherB=0x6D8F4B15 (Rivest vector 1, little-endian words).
- Address trace: after acceptance, oS_address shows 0,1,2,...,25,25 on consecutive cycles; a bench RAM with 1-cycle read latency returns the matching S.
- iStart=1 with iKeyReady=0 for 5 cycles -> oBusy stays 0; raising iKeyReady then accepts on that cycle and ignores the earlier requests.
- iStart pulsed at cycle 10 of an operation with different plaintext -> result matches the first block only; no second oDone.
- rst asserted at RUN j=12 -> next cycle oBusy=0, oS_address=0, oCipherA/B=0, no oDone; a fresh request afterwards yields the correct ciphertext.
